mod_sub_pipe: RTL and testbench

- Pipelined modular subtractor: out = (a - b) mod MODULUS, for a, b in [0, MODULUS).
- Counterpart of the 4-bit carry-lookahead adder group used in the butterfly add path. Subtraction is built from 4-bit borrow-lookahead groups instead of carry groups.
- Sits on the butterfly difference leg of the R16 datapath. Uses a valid/ready handshake so the FFT scheduler can stall it.

---
 rtl/fft_arith_pkg.sv | 23 ++
 rtl/mod_sub_pipe_bla4.sv | 40 ++++
 rtl/mod_sub_pipe_cla4.sv | 38 +++
 rtl/mod_sub_pipe.sv | 157 +++++++++++++++
 tb/tb_mod_sub_pipe.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_arith_pkg
//  Description : Shared constants for the R16 FFT modular arithmetic datapath
//                (field modulus, datapath widths, lookahead group size).
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_arith_pkg;

  // Datapath operand/result width in bits (multiple of the group size).
  localparam int unsigned c_width = 64;

  // Width of the sideband tag carried alongside each operand pair.
  localparam int unsigned c_tag_w = 4;

  // Width of one lookahead group (carry or borrow).
  localparam int unsigned c_group_w = 4;

  // Prime field modulus 2^64 - 2^32 + 1.
  localparam logic [63:0] c_modulus = 64'hFFFFFFFF00000001;

endpackage : fft_arith_pkg
`default_nettype wire

// File: rtl/mod_sub_pipe_bla4.sv
`default_nettype none
// ============================================================================
//  Module      : bla4
//  Description : 4-bit borrow-lookahead subtractor group. Produces a - b - b_in
//                for one nibble plus group borrow generate/propagate so that
//                groups can be chained by the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module bla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       b_in,
  output logic [3:0] diff,
  output logic       g_out,
  output logic       p_out
);

  logic [3:0] w_gb;   // bit borrows out regardless of incoming borrow
  logic [3:0] w_pb;   // bit passes an incoming borrow through
  logic [3:0] w_br;   // borrow into each bit position

  assign w_gb = ~a & b;
  assign w_pb = ~(a ^ b);

  // Flat lookahead: every internal borrow is a two-level function of b_in.
  assign w_br[0] = b_in;
  assign w_br[1] = w_gb[0] | (w_pb[0] & b_in);
  assign w_br[2] = w_gb[1] | (w_pb[1] & w_gb[0]) | (w_pb[1] & w_pb[0] & b_in);
  assign w_br[3] = w_gb[2] | (w_pb[2] & w_gb[1]) | (w_pb[2] & w_pb[1] & w_gb[0])
                 | (w_pb[2] & w_pb[1] & w_pb[0] & b_in);

  assign diff  = a ^ b ^ w_br;

  // Group terms let the parent compute the next group's borrow-in directly.
  assign g_out = w_gb[3] | (w_pb[3] & w_gb[2]) | (w_pb[3] & w_pb[2] & w_gb[1])
               | (w_pb[3] & w_pb[2] & w_pb[1] & w_gb[0]);
  assign p_out = &w_pb;

endmodule : bla4
`default_nettype wire

// File: rtl/mod_sub_pipe_cla4.sv
`default_nettype none
// ============================================================================
//  Module      : cla4
//  Description : 4-bit carry-lookahead adder group, as used in the butterfly
//                add path. Produces a + b + c_in for one nibble plus group
//                carry generate/propagate for chaining.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       g_out,
  output logic       p_out
);

  logic [3:0] w_g;    // bit generates a carry
  logic [3:0] w_p;    // bit propagates an incoming carry
  logic [3:0] w_c;    // carry into each bit position

  assign w_g = a & b;
  assign w_p = a ^ b;

  assign w_c[0] = c_in;
  assign w_c[1] = w_g[0] | (w_p[0] & c_in);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & c_in);

  assign sum   = w_p ^ w_c;

  assign g_out = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign p_out = &w_p;

endmodule : cla4
`default_nettype wire

// File: rtl/mod_sub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mod_sub_pipe
//  Description : Two-stage pipelined modular subtractor, diff = (a - b) mod
//                MODULUS, with valid/ready flow control and a sticky
//                out-of-range operand flag. S1 subtracts with chained
//                borrow-lookahead groups; S2 adds MODULUS back on borrow.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_sub_pipe
  import fft_arith_pkg::*;
#(
  parameter int unsigned       WIDTH   = c_width,
  parameter logic [WIDTH-1:0]  MODULUS = c_modulus,
  parameter int unsigned       TAG_W   = c_tag_w
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             range_err
);

  localparam int unsigned c_ngroups = WIDTH / c_group_w;

  // --------------------------------------------------------------------------
  // Pipeline state
  // --------------------------------------------------------------------------
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_raw;
  logic             r_s1_borrow;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_diff;
  logic [TAG_W-1:0] r_s2_tag;

  logic             r_range_err;

  // --------------------------------------------------------------------------
  // Flow control: each stage advances when it is empty or its successor does.
  // in_ready depends only on pipeline state and out_ready, never on in_valid.
  // --------------------------------------------------------------------------
  logic w_adv1;
  logic w_adv2;
  logic w_accept;
  logic w_range_bad;

  assign w_adv2      = ~r_s2_valid | out_ready;
  assign w_adv1      = ~r_s1_valid | w_adv2;
  assign w_accept    = in_valid & w_adv1;
  assign w_range_bad = (a_in >= MODULUS) | (b_in >= MODULUS);

  assign in_ready  = w_adv1;
  assign out_valid = r_s2_valid;
  assign diff_out  = r_s2_diff;
  assign tag_out   = r_s2_tag;
  assign range_err = r_range_err;

  // --------------------------------------------------------------------------
  // S1 datapath: a - b through a chain of borrow-lookahead groups. The final
  // group borrow is the only sign information kept; no WIDTH+1-bit result.
  // --------------------------------------------------------------------------
  logic [c_ngroups:0]   w_sub_br;
  logic [c_ngroups-1:0] w_sub_g;
  logic [c_ngroups-1:0] w_sub_p;
  logic [WIDTH-1:0]     w_raw;

  assign w_sub_br[0] = 1'b0;

  for (genvar gi = 0; gi < c_ngroups; gi++) begin : g_sub
    bla4 u_bla4 (
      .a     (a_in[gi*c_group_w +: c_group_w]),
      .b     (b_in[gi*c_group_w +: c_group_w]),
      .b_in  (w_sub_br[gi]),
      .diff  (w_raw[gi*c_group_w +: c_group_w]),
      .g_out (w_sub_g[gi]),
      .p_out (w_sub_p[gi])
    );
    assign w_sub_br[gi+1] = w_sub_g[gi] | (w_sub_p[gi] & w_sub_br[gi]);
  end

  // --------------------------------------------------------------------------
  // S2 datapath: when S1 borrowed, raw holds a - b + 2^WIDTH; adding MODULUS
  // and dropping the carry-out yields a - b + MODULUS.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]     w_addend;
  logic [c_ngroups:0]   w_add_c;
  logic [c_ngroups-1:0] w_add_g;
  logic [c_ngroups-1:0] w_add_p;
  logic [WIDTH-1:0]     w_fixed;

  assign w_addend   = r_s1_borrow ? MODULUS : '0;
  assign w_add_c[0] = 1'b0;

  for (genvar gi = 0; gi < c_ngroups; gi++) begin : g_fix
    cla4 u_cla4 (
      .a     (r_s1_raw[gi*c_group_w +: c_group_w]),
      .b     (w_addend[gi*c_group_w +: c_group_w]),
      .c_in  (w_add_c[gi]),
      .sum   (w_fixed[gi*c_group_w +: c_group_w]),
      .g_out (w_add_g[gi]),
      .p_out (w_add_p[gi])
    );
    assign w_add_c[gi+1] = w_add_g[gi] | (w_add_p[gi] & w_add_c[gi]);
  end

  // S1 register: capture raw difference, borrow and tag on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_raw    <= '0;
      r_s1_borrow <= 1'b0;
      r_s1_tag    <= '0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_raw    <= w_raw;
        r_s1_borrow <= w_sub_br[c_ngroups];
        r_s1_tag    <= tag_in;
      end
    end
  end

  // S2 register: capture corrected result; holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_diff  <= '0;
      r_s2_tag   <= '0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_diff <= w_fixed;
        r_s2_tag  <= r_s1_tag;
      end
    end
  end

  // Sticky flag for any accepted operand outside [0, MODULUS).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_range_err <= 1'b0;
    end else if (w_accept && w_range_bad) begin
      r_range_err <= 1'b1;
    end
  end

endmodule : mod_sub_pipe
`default_nettype wire

// File: tb/tb_mod_sub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_sub_pipe
//  Description : Self-checking bench for mod_sub_pipe. Directed scenarios plus
//                randomized traffic with random backpressure; expected results
//                come from plain modular arithmetic and are queued at
//                acceptance, then compared by an independent output monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mod_sub_pipe;

  localparam logic [63:0] c_m = 64'hFFFFFFFF00000001;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff_out;
  logic [3:0]  tag_out;
  logic        range_err;

  logic        rand_mode;
  logic        rand_rdy;
  logic        fix_rdy;

  typedef struct {
    logic [63:0] diff;
    logic [3:0]  tag;
    bit          chk;
  } exp_t;

  exp_t sb[$];

  int n_checks;
  int n_pass;

  // Monitor-local state
  bit          mon_stalled;
  logic [63:0] mon_hold_diff;
  logic [3:0]  mon_hold_tag;
  exp_t        mon_e;

  mod_sub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff_out  (diff_out),
    .tag_out   (tag_out),
    .range_err (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign out_ready = rand_mode ? rand_rdy : fix_rdy;

  // Random downstream backpressure, changed on the falling edge.
  always @(negedge clk) rand_rdy = ($urandom_range(0, 3) != 0);

  // Reference: (a - b) mod M computed with wide unsigned arithmetic.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] t;
    t = ({64'd0, a} + {64'd0, c_m} - {64'd0, b}) % {64'd0, c_m};
    return t[63:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: actual=event required=no-event", name);
  endtask

  // Present one operand pair starting at a falling edge; returns at the
  // falling edge after the accepting rising edge.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [3:0] t,
                      input bit chk, output int waited);
    exp_t e;
    waited   = 0;
    a_in     = a;
    b_in     = b;
    tag_in   = t;
    in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      fail_now("send_timeout");
    end else begin
      e.diff = model(a, b);
      e.tag  = t;
      e.chk  = chk;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  // Output monitor: pops the scoreboard on every transfer and checks that a
  // stalled output holds its value.
  initial begin
    mon_stalled = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        mon_stalled = 1'b0;
      end else begin
        if (mon_stalled) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_diff", diff_out, mon_hold_diff);
          check("hold_tag", 64'(tag_out), 64'(mon_hold_tag));
        end
        mon_stalled = 1'b0;
        if (out_valid) begin
          if (out_ready) begin
            if (sb.size() == 0) begin
              fail_now("unexpected_output");
            end else begin
              mon_e = sb.pop_front();
              check("out_tag", 64'(tag_out), 64'(mon_e.tag));
              if (mon_e.chk) check("out_diff", diff_out, mon_e.diff);
            end
          end else begin
            mon_stalled   = 1'b1;
            mon_hold_diff = diff_out;
            mon_hold_tag  = tag_out;
          end
        end
      end
    end
  end

  // Bound on total run time.
  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] rand_op();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = 64'd0;
      1:       v = c_m - 64'd1;
      2:       v = 64'd1;
      default: begin
        v = {$urandom, $urandom};
        v = v % c_m;
      end
    endcase
    return v;
  endfunction

  // Stimulus sequence.
  initial begin
    int w;
    logic [63:0] ra;
    logic [63:0] rb;

    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    tag_in    = '0;
    fix_rdy   = 1'b1;
    rand_mode = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_diff", diff_out, 64'd0);
    check("rst_tag", 64'(tag_out), 64'd0);
    check("rst_range_err", 64'(range_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Basic subtraction and two-cycle latency.
    send(64'd5, 64'd3, 4'h1, 1'b1, w);
    check("lat_not_yet", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_diff", diff_out, 64'd2);
    check("lat_tag", 64'(tag_out), 64'h1);
    check("lat_range_err", 64'(range_err), 64'd0);
    drain();

    // Wrap-around and boundary operands.
    send(64'd3, 64'd5, 4'h2, 1'b1, w);
    send(64'd0, 64'hFFFFFFFF00000000, 4'h3, 1'b1, w);
    send(64'h1234, 64'h1234, 4'h4, 1'b1, w);
    drain();

    // Back-to-back at full throughput.
    for (int i = 0; i < 8; i++) begin
      send(rand_op(), rand_op(), 4'(i + 8), 1'b1, w);
      check("b2b_no_wait", 64'(w), 64'd0);
    end
    drain();

    // Backpressure: fill both stages, confirm stall, release.
    fix_rdy = 1'b0;
    send(64'd10, 64'd1, 4'h1, 1'b1, w);
    send(64'd20, 64'd2, 4'h2, 1'b1, w);
    #1;
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_tag_head", 64'(tag_out), 64'h1);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("bp_tag_stable", 64'(tag_out), 64'h1);
      check("bp_diff_stable", diff_out, 64'd9);
    end
    fix_rdy = 1'b1;
    send(64'd30, 64'd3, 4'h3, 1'b1, w);
    check("bp_rel_tag2", 64'(tag_out), 64'h2);
    check("bp_rel_valid2", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("bp_rel_tag3", 64'(tag_out), 64'h3);
    check("bp_rel_valid3", 64'(out_valid), 64'd1);
    drain();

    // Sticky range error.
    send(c_m, 64'd0, 4'h5, 1'b0, w);
    check("range_set", 64'(range_err), 64'd1);
    send(64'd7, 64'd2, 4'h6, 1'b1, w);
    drain();
    check("range_sticky", 64'(range_err), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("range_cleared", 64'(range_err), 64'd0);
    @(negedge clk);

    // Reset with both stages occupied discards their contents.
    fix_rdy = 1'b0;
    send(64'd100, 64'd1, 4'h7, 1'b1, w);
    send(64'd200, 64'd2, 4'h8, 1'b1, w);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_diff", diff_out, 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    fix_rdy = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      check("no_stale_output", 64'(out_valid), 64'd0);
    end

    // Randomized traffic with random backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = rand_op();
      rb = ($urandom_range(0, 9) == 0) ? ra : rand_op();
      send(ra, rb, 4'($urandom), 1'b1, w);
      if ($urandom_range(0, 7) == 0) @(negedge clk);
    end
    drain();
    check("rand_range_err", 64'(range_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mod_sub_pipe
`default_nettype wire
